// File: rtl/wb_arbiter.sv
// Two-requester round-robin arbiter in front of a single Wishbone master port.
// A requester holds its i_Req bit until it sees its o_Done pulse. Each
// transaction either completes on i_wb_ack or aborts after TIMEOUT_CYCLES
// cycles of strobe with o_Timeout set.
module wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       i_Clock,
  input  logic       i_Rstn,
  input  logic [1:0] i_Req,
  input  logic [1:0] i_We,
  input  logic [7:0] i_Addr0,
  input  logic [7:0] i_Addr1,
  input  logic [7:0] i_Wdata0,
  input  logic [7:0] i_Wdata1,
  output logic [1:0] o_Done,
  output logic [7:0] o_Rdata,
  output logic       o_Timeout,
  output logic       o_wb_cyc,
  output logic       o_wb_stb,
  output logic       o_wb_we,
  output logic [7:0] o_wb_adr,
  output logic [7:0] o_wb_dat,
  input  logic [7:0] i_wb_dat,
  input  logic       i_wb_ack,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter hits this value on the last strobe cycle before the abort.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       grant_q, grant_d;
  logic       cyc_d, stb_d, we_d, to_d;
  logic [7:0] adr_d, dat_d, rdata_d;
  logic [1:0] done_d;

  assign o_dbg_state = state_q;

  // State and every output are registered; last-grant resets to 1 so
  // requester 0 wins the first contention.
  always_ff @(posedge i_Clock or negedge i_Rstn) begin
    if (!i_Rstn) begin
      state_q   <= IDLE;
      cnt_q     <= 8'h00;
      last_q    <= 1'b1;
      grant_q   <= 1'b0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_adr  <= 8'h00;
      o_wb_dat  <= 8'h00;
      o_Rdata   <= 8'h00;
      o_Done    <= 2'b00;
      o_Timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      o_wb_cyc  <= cyc_d;
      o_wb_stb  <= stb_d;
      o_wb_we   <= we_d;
      o_wb_adr  <= adr_d;
      o_wb_dat  <= dat_d;
      o_Rdata   <= rdata_d;
      o_Done    <= done_d;
      o_Timeout <= to_d;
    end
  end

  // Next-state and next-output logic; bus fields hold their value between
  // grants, done/timeout default to a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    cyc_d   = o_wb_cyc;
    stb_d   = o_wb_stb;
    we_d    = o_wb_we;
    adr_d   = o_wb_adr;
    dat_d   = o_wb_dat;
    rdata_d = o_Rdata;
    done_d  = 2'b00;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|i_Req) begin
          if (&i_Req) grant_d = ~last_q;
          else        grant_d = i_Req[1];
          we_d    = grant_d ? i_We[1]  : i_We[0];
          adr_d   = grant_d ? i_Addr1  : i_Addr0;
          dat_d   = grant_d ? i_Wdata1 : i_Wdata0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = 8'h00;
          state_d = BUS;
        end
      end
      BUS: begin
        // An ack wins over a timeout reached in the same cycle.
        if (i_wb_ack) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          if (!o_wb_we) rdata_d = i_wb_dat;
          done_d  = grant_q ? 2'b10 : 2'b01;
          last_d  = grant_q;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          rdata_d = 8'h00;
          done_d  = grant_q ? 2'b10 : 2'b01;
          to_d    = 1'b1;
          last_d  = grant_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with TIMEOUT_CYCLES=4: a table of complete
// transactions plus hand-written sequences for reset, request drop and
// stray acks.
module tb_wb_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req, we;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic [1:0] o_done;
  logic [7:0] o_rdata;
  logic       o_timeout;
  logic       wb_cyc, wb_stb, wb_we;
  logic [7:0] wb_adr, wb_dat_out, wb_dat_in;
  logic       wb_ack;
  logic [1:0] dbg_state;

  int n_vec;
  int n_err;

  wb_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .i_Clock    (clk),
    .i_Rstn     (rst_n),
    .i_Req      (req),
    .i_We       (we),
    .i_Addr0    (addr0),
    .i_Addr1    (addr1),
    .i_Wdata0   (wdata0),
    .i_Wdata1   (wdata1),
    .o_Done     (o_done),
    .o_Rdata    (o_rdata),
    .o_Timeout  (o_timeout),
    .o_wb_cyc   (wb_cyc),
    .o_wb_stb   (wb_stb),
    .o_wb_we    (wb_we),
    .o_wb_adr   (wb_adr),
    .o_wb_dat   (wb_dat_out),
    .i_wb_dat   (wb_dat_in),
    .i_wb_ack   (wb_ack),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] a0, a1, d0, d1;
    int         ack_at;     // strobe cycle carrying ack, 0 = never
    logic [7:0] sdat;
    logic [1:0] req_after;  // i_Req applied the cycle after o_Done
    logic [1:0] exp_done;
    logic       exp_we;
    logic [7:0] exp_adr, exp_dat, exp_rdata;
    logic       exp_to;
    int         exp_stb;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one transaction and act as the Wishbone slave.
  task automatic run_vec(input vec_t v, input int idx);
    int  stb_n;
    bit  seen, done_seen;
    @(negedge clk);
    req = v.req; we = v.we; addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (wb_stb) seen = 1;
    end
    check($sformatf("v%0d stb_seen", idx), 32'(seen), 32'd1);
    if (seen) begin
      check($sformatf("v%0d adr", idx), 32'(wb_adr), 32'(v.exp_adr));
      check($sformatf("v%0d we", idx), 32'(wb_we), 32'(v.exp_we));
      check($sformatf("v%0d dat", idx), 32'(wb_dat_out), 32'(v.exp_dat));
      check($sformatf("v%0d cyc", idx), 32'(wb_cyc), 32'd1);
      stb_n = 0;
      done_seen = 0;
      for (int i = 0; i < 20 && !done_seen; i++) begin
        stb_n++;
        if (stb_n == v.ack_at) begin
          wb_ack = 1'b1;
          wb_dat_in = v.sdat;
        end
        @(posedge clk); #1;
        wb_ack = 1'b0;
        wb_dat_in = 8'hEE;
        if (o_done != 2'b00) done_seen = 1;
      end
      check($sformatf("v%0d done_seen", idx), 32'(done_seen), 32'd1);
      check($sformatf("v%0d done", idx), 32'(o_done), 32'(v.exp_done));
      check($sformatf("v%0d rdata", idx), 32'(o_rdata), 32'(v.exp_rdata));
      check($sformatf("v%0d timeout", idx), 32'(o_timeout), 32'(v.exp_to));
      check($sformatf("v%0d stb_cycles", idx), 32'(stb_n), 32'(v.exp_stb));
      check($sformatf("v%0d cyc_stb_low", idx), {30'd0, wb_cyc, wb_stb}, 32'd0);
      req = v.req_after;
      @(posedge clk); #1;
      check($sformatf("v%0d done_pulse", idx), {29'd0, o_done, o_timeout}, 32'd0);
      check($sformatf("v%0d rdata_hold", idx), 32'(o_rdata), 32'(v.exp_rdata));
    end
  endtask

  initial begin
    bit seen;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req = 2'b00; we = 2'b00; addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    wb_dat_in = 8'hEE;
    wb_ack = 1'b0;

    //           req    we     a0     a1     d0     d1   ack sdat   after  done   we    adr    dat    rdata  to   stb
    vecs[0] = '{2'b01, 2'b00, 8'h66, 8'h00, 8'h12, 8'h00, 1, 8'hA5, 2'b00, 2'b01, 1'b0, 8'h66, 8'h12, 8'hA5, 1'b0, 1};
    vecs[1] = '{2'b10, 2'b10, 8'h00, 8'h5E, 8'h00, 8'h3C, 1, 8'h77, 2'b00, 2'b10, 1'b1, 8'h5E, 8'h3C, 8'hA5, 1'b0, 1};
    vecs[2] = '{2'b11, 2'b00, 8'h11, 8'h22, 8'h01, 8'h02, 2, 8'hB1, 2'b10, 2'b01, 1'b0, 8'h11, 8'h01, 8'hB1, 1'b0, 2};
    vecs[3] = '{2'b10, 2'b00, 8'h11, 8'h22, 8'h01, 8'h02, 1, 8'hB2, 2'b11, 2'b10, 1'b0, 8'h22, 8'h02, 8'hB2, 1'b0, 1};
    vecs[4] = '{2'b11, 2'b00, 8'h31, 8'h32, 8'h03, 8'h04, 1, 8'hC4, 2'b11, 2'b01, 1'b0, 8'h31, 8'h03, 8'hC4, 1'b0, 1};
    vecs[5] = '{2'b11, 2'b00, 8'h41, 8'h42, 8'h05, 8'h06, 3, 8'hC5, 2'b11, 2'b10, 1'b0, 8'h42, 8'h06, 8'hC5, 1'b0, 3};
    vecs[6] = '{2'b11, 2'b01, 8'h51, 8'h52, 8'h9A, 8'h9B, 1, 8'h55, 2'b11, 2'b01, 1'b1, 8'h51, 8'h9A, 8'hC5, 1'b0, 1};
    vecs[7] = '{2'b11, 2'b00, 8'h61, 8'h62, 8'h07, 8'h08, 0, 8'h00, 2'b00, 2'b10, 1'b0, 8'h62, 8'h08, 8'h00, 1'b1, 4};
    vecs[8] = '{2'b01, 2'b00, 8'h71, 8'h72, 8'h09, 8'h0A, 4, 8'hD8, 2'b00, 2'b01, 1'b0, 8'h71, 8'h09, 8'hD8, 1'b0, 4};
    vecs[9] = '{2'b10, 2'b00, 8'h81, 8'h82, 8'h0B, 8'h0C, 0, 8'h00, 2'b00, 2'b10, 1'b0, 8'h82, 8'h0C, 8'h00, 1'b1, 4};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus", {29'd0, wb_cyc, wb_stb, wb_we}, 32'd0);
    check("rst_adr_dat", {16'd0, wb_adr, wb_dat_out}, 32'd0);
    check("rst_done_to_rdata", {21'd0, o_done, o_timeout, o_rdata}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // stray acks in IDLE must not start or complete anything
    @(negedge clk);
    req = 2'b00;
    wb_ack = 1'b1;
    wb_dat_in = 8'hFF;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_ack_done", 32'(o_done), 32'd0);
      check("idle_ack_cyc", 32'(wb_cyc), 32'd0);
      check("idle_ack_rdata", 32'(o_rdata), 32'h00);
    end
    wb_ack = 1'b0;
    wb_dat_in = 8'hEE;

    // request dropped and inputs changed mid-transaction (last grant was 1)
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr0 = 8'h70; wdata0 = 8'h44;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (wb_stb) seen = 1;
    end
    check("drop_stb_seen", 32'(seen), 32'd1);
    req = 2'b00; we = 2'b11; addr0 = 8'h71; wdata0 = 8'h45;
    @(posedge clk); #1;
    check("drop_stb_held", 32'(wb_stb), 32'd1);
    check("drop_adr_held", 32'(wb_adr), 32'h70);
    check("drop_dat_held", 32'(wb_dat_out), 32'h44);
    check("drop_we_held", 32'(wb_we), 32'd0);
    wb_ack = 1'b1;
    wb_dat_in = 8'h5A;
    @(posedge clk); #1;
    wb_ack = 1'b0;
    wb_dat_in = 8'hEE;
    check("drop_done", 32'(o_done), 32'h1);
    check("drop_rdata", 32'(o_rdata), 32'h5A);
    @(posedge clk); #1;
    check("drop_done_pulse", 32'(o_done), 32'd0);

    // reset mid-bus: requester 1 granted, then reset asserted during strobe
    @(negedge clk);
    we = 2'b00;
    req = 2'b10; addr1 = 8'h93;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      if (wb_stb) seen = 1;
    end
    check("rstbus_stb_seen", 32'(seen), 32'd1);
    check("rstbus_adr", 32'(wb_adr), 32'h93);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstbus_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
    check("rstbus_adr_clr", 32'(wb_adr), 32'h00);
    wb_ack = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("rstbus_no_done", 32'(o_done), 32'd0);
    end
    wb_ack = 1'b0;
    @(negedge clk);
    req = 2'b00;
    rst_n = 1'b1;
    // last-grant is back to 1, so contention goes to requester 0
    run_vec('{2'b11, 2'b00, 8'hA0, 8'hA1, 8'h0D, 8'h0E, 1, 8'h3E, 2'b00,
              2'b01, 1'b0, 8'hA0, 8'h0D, 8'h3E, 1'b0, 1}, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
